// File: rtl/event_serializer.sv
// Event serializer: collects per-device join/leave requests for four devices,
// keeps one pending event per device, and emits at most one event per cycle
// through a round-robin arbiter so the downstream monitor never sees a
// duplicate. The join/leave inputs are named join_req/leave_req because
// "join" is a reserved word in SystemVerilog.
module event_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] join_req,
  input  logic [3:0] leave_req,
  output logic       change,
  output logic       on_off,
  output logic [1:0] dev_id,
  output logic [3:0] active_mask,
  output logic       dup_err
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PEND_JOIN  = 2'd1;
  localparam logic [1:0] ST_PEND_LEAVE = 2'd2;

  logic [1:0] pend_state_reg  [4];
  logic [1:0] pend_state_next [4];
  logic [3:0] present_next;
  logic [3:0] pending_vec;
  logic [3:0] rejected;
  logic [1:0] rr_ptr_reg;
  logic       grant_valid;
  logic [1:0] grant_idx;

  // Round-robin search: first pending device at or after rr_ptr, cyclically.
  // Iterating from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    logic [1:0] idx;
    idx         = 2'd0;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr_reg + 2'(k);
      if (pending_vec[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Per-device request evaluation. Requests are always judged against the
  // pre-edge effective state, even when the same device is being granted;
  // in that case an accepted request becomes a fresh pending event instead
  // of cancelling the one that is leaving now.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dev
      logic eff_on;
      logic join_ok;
      logic leave_ok;
      logic granted;

      assign eff_on   = (pend_state_reg[gi] == ST_PEND_JOIN) ||
                        ((pend_state_reg[gi] == ST_IDLE) && active_mask[gi]);
      assign join_ok  = join_req[gi] && !leave_req[gi] && !eff_on;
      assign leave_ok = leave_req[gi] && !join_req[gi] && eff_on;
      assign granted  = grant_valid && (grant_idx == 2'(gi));

      // Both-high, join-while-on and leave-while-off are all refused.
      assign rejected[gi]    = (join_req[gi] || leave_req[gi]) && !join_ok && !leave_ok;
      assign pending_vec[gi] = (pend_state_reg[gi] != ST_IDLE);

      assign present_next[gi] = granted ? (pend_state_reg[gi] == ST_PEND_JOIN)
                                        : active_mask[gi];

      assign pend_state_next[gi] =
          granted  ? (join_ok  ? ST_PEND_JOIN :
                      leave_ok ? ST_PEND_LEAVE : ST_IDLE) :
          join_ok  ? ((pend_state_reg[gi] == ST_PEND_LEAVE) ? ST_IDLE : ST_PEND_JOIN) :
          leave_ok ? ((pend_state_reg[gi] == ST_PEND_JOIN)  ? ST_IDLE : ST_PEND_LEAVE) :
                     pend_state_reg[gi];
    end
  endgenerate

  // Pending state per device; reset drops any event not yet emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pend_state_reg[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        pend_state_reg[i] <= pend_state_next[i];
      end
    end
  end

  // Registered event outputs, presence mask, arbiter pointer and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      change      <= 1'b0;
      on_off      <= 1'b0;
      dev_id      <= 2'd0;
      active_mask <= 4'd0;
      dup_err     <= 1'b0;
      rr_ptr_reg  <= 2'd0;
    end else begin
      change      <= grant_valid;
      on_off      <= grant_valid && (pend_state_reg[grant_idx] == ST_PEND_JOIN);
      dev_id      <= grant_valid ? grant_idx : 2'd0;
      active_mask <= present_next;
      dup_err     <= dup_err || (|rejected);
      if (grant_valid) begin
        rr_ptr_reg <= grant_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_event_serializer.sv
// Self-checking bench for event_serializer. The reference model tracks, per
// device, the "desired" state (what the last accepted request asked for) and
// the "present" state (what has been announced downstream); a device has an
// event outstanding exactly when the two differ.
module tb_event_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] join_req;
  logic [3:0] leave_req;
  logic       change;
  logic       on_off;
  logic [1:0] dev_id;
  logic [3:0] active_mask;
  logic       dup_err;

  int checks = 0;
  int errors = 0;
  int ev_count = 0;
  int ev_sum = 0;

  // reference model state
  bit m_des [4];
  bit m_pres[4];
  int m_rr;
  bit e_change;
  bit e_on_off;
  int e_dev;
  bit e_err;
  int m_g;
  int m_idx;

  event_serializer dut (
    .clk(clk),
    .rst(rst),
    .join_req(join_req),
    .leave_req(leave_req),
    .change(change),
    .on_off(on_off),
    .dev_id(dev_id),
    .active_mask(active_mask),
    .dup_err(dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_mask();
    int m;
    m = 0;
    for (int i = 0; i < 4; i++) if (m_pres[i]) m |= (1 << i);
    return m;
  endfunction

  // Reference model: grant from the pre-edge view, then apply requests
  // against the pre-edge desired state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_des[i]  = 1'b0;
        m_pres[i] = 1'b0;
      end
      m_rr = 0; e_change = 0; e_on_off = 0; e_dev = 0; e_err = 0;
    end else begin
      m_g = -1;
      for (int k = 0; k < 4; k++) begin
        m_idx = (m_rr + k) % 4;
        if (m_g < 0 && m_des[m_idx] != m_pres[m_idx]) m_g = m_idx;
      end
      if (m_g >= 0) begin
        e_change = 1; e_on_off = m_des[m_g]; e_dev = m_g;
        m_pres[m_g] = m_des[m_g];
        m_rr = (m_g + 1) % 4;
      end else begin
        e_change = 0; e_on_off = 0; e_dev = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (join_req[i] && leave_req[i]) e_err = 1;
        else if (join_req[i]) begin
          if (m_des[i]) e_err = 1; else m_des[i] = 1'b1;
        end else if (leave_req[i]) begin
          if (!m_des[i]) e_err = 1; else m_des[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus the running join/leave sum.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ev_sum = 0;
      end else begin
        chk("change", int'(change), int'(e_change));
        chk("on_off", int'(on_off), int'(e_on_off));
        chk("dev_id", int'(dev_id), e_dev);
        chk("active_mask", int'(active_mask), exp_mask());
        chk("dup_err", int'(dup_err), int'(e_err));
        if (change) begin
          ev_count++;
          ev_sum += on_off ? 1 : -1;
        end
        chk("sum_vs_popcount", ev_sum, $countones(active_mask));
      end
    end
  end

  task automatic cyc(input logic [3:0] j, input logic [3:0] l);
    @(negedge clk);
    join_req  = j;
    leave_req = l;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    join_req = 4'd0;
    leave_req = 4'd0;
    @(posedge clk);
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    join_req = 4'd0;
    leave_req = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_change", int'(change), 0);
    chk("rst_mask", int'(active_mask), 0);
    chk("rst_dup_err", int'(dup_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // single join on device 0
    cyc(4'b0001, 4'b0000);
    chk("t1_no_event_yet", int'(change), 0);
    cyc(4'b0000, 4'b0000);
    chk("t1_change", int'(change), 1);
    chk("t1_on_off", int'(on_off), 1);
    chk("t1_dev", int'(dev_id), 0);
    chk("t1_mask", int'(active_mask), 1);
    chk("t1_err", int'(dup_err), 0);
    cyc(4'b0000, 4'b0000);
    chk("t1_change_drop", int'(change), 0);

    // all four join together: four back-to-back events
    do_reset();
    cyc(4'b1111, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0000, 4'b0000);
      chk("t2_change", int'(change), 1);
      chk("t2_dev", int'(dev_id), k);
    end
    cyc(4'b0000, 4'b0000);
    chk("t2_idle", int'(change), 0);
    chk("t2_mask", int'(active_mask), 15);

    // join[1] held three cycles: one event, duplicate flagged
    do_reset();
    base = ev_count;
    cyc(4'b0010, 4'b0000);
    cyc(4'b0010, 4'b0000);
    cyc(4'b0010, 4'b0000);
    idle(3);
    chk("t3_events", ev_count - base, 1);
    chk("t3_err", int'(dup_err), 1);
    chk("t3_mask", int'(active_mask), 2);

    // join and leave together on device 3
    do_reset();
    cyc(4'b0001, 4'b0000);
    idle(1);
    base = ev_count;
    cyc(4'b1000, 4'b1000);
    idle(3);
    chk("t4_events", ev_count - base, 0);
    chk("t4_mask", int'(active_mask), 1);
    chk("t4_err", int'(dup_err), 1);

    // leave of an off-line device
    do_reset();
    base = ev_count;
    cyc(4'b0000, 4'b0100);
    idle(2);
    chk("t5_events", ev_count - base, 0);
    chk("t5_err", int'(dup_err), 1);

    // leave then join on device 2 while it is being granted
    do_reset();
    cyc(4'b0100, 4'b0000);
    idle(2);
    cyc(4'b0000, 4'b0100);
    cyc(4'b0100, 4'b0000);
    chk("t6_leave_change", int'(change), 1);
    chk("t6_leave_onoff", int'(on_off), 0);
    chk("t6_leave_dev", int'(dev_id), 2);
    chk("t6_leave_mask", int'(active_mask), 0);
    cyc(4'b0000, 4'b0000);
    chk("t6_join_change", int'(change), 1);
    chk("t6_join_onoff", int'(on_off), 1);
    chk("t6_join_dev", int'(dev_id), 2);
    chk("t6_mask", int'(active_mask), 4);
    chk("t6_err", int'(dup_err), 0);

    // leave then join on device 2 while others hold the grant: cancelled
    do_reset();
    cyc(4'b0100, 4'b0000);
    idle(2);
    base = ev_count;
    cyc(4'b0011, 4'b0100);
    cyc(4'b0100, 4'b0000);
    chk("t7_dev0", int'(dev_id), 0);
    cyc(4'b0000, 4'b0000);
    chk("t7_dev1", int'(dev_id), 1);
    idle(2);
    chk("t7_events", ev_count - base, 2);
    chk("t7_mask", int'(active_mask), 7);
    chk("t7_err", int'(dup_err), 0);

    // asynchronous reset in the middle of a burst
    do_reset();
    cyc(4'b0011, 4'b0000);
    cyc(4'b0000, 4'b0000);
    chk("t8_pre_change", int'(change), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t8_async_change", int'(change), 0);
    chk("t8_async_mask", int'(active_mask), 0);
    chk("t8_async_dev", int'(dev_id), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = ev_count;
    idle(5);
    chk("t8_events", ev_count - base, 0);
    chk("t8_mask", int'(active_mask), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_serializer.md
EVENT_SERIALIZER -- requirements
Module: event_serializer

Interface
REQ-001 Parameter: none; the device count is fixed at 4, indices 0..3.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 join  input  4  bit i high for one or more cycles: device i requests to go on-line; sampled each rising edge.
REQ-005 leave  input  4  bit i high: device i requests to go off-line; sampled each rising edge.
REQ-006 change  output  1  registered; high for one cycle per emitted event; drives the downstream monitor's change input.
REQ-007 on_off  output  1  registered; 1 = join event, 0 = leave event; meaningful only when change=1, else 0.
REQ-008 dev_id  output  2  registered; index of the device whose event is emitted; 0 when change=0.
REQ-009 active_mask  output  4  registered; bit i = 1 if device i's last emitted event was a join.
REQ-010 dup_err  output  1  sticky; set on any rejected request (REQ-014, REQ-015); cleared only by reset.

Function
REQ-011 Per device: present[i] (= active_mask[i]) and a pending state in {IDLE, PEND_JOIN, PEND_LEAVE}.
REQ-012 Effective state of device i: PEND_JOIN -> on; PEND_LEAVE -> off; IDLE -> present[i].
REQ-013 An accepted join applies only when effective state is off: IDLE -> PEND_JOIN; PEND_LEAVE -> IDLE (cancel, no event emitted). An accepted leave applies only when effective state is on: IDLE -> PEND_LEAVE; PEND_JOIN -> IDLE (cancel).
REQ-014 join when effective on, or leave when effective off: request ignored, dup_err set.
REQ-015 join[i] and leave[i] both high in the same cycle: both ignored, dup_err set.
REQ-016 A level held high counts once per sampled edge; second and later samples fall under REQ-014.
REQ-017 Arbiter: each edge, if any device is pending, grant the first pending index found searching cyclically from rr_ptr; then rr_ptr <= grant+1 mod 4. If nothing is pending, rr_ptr holds.
REQ-018 On grant of device g at edge N: change=1, on_off=(state==PEND_JOIN), dev_id=g from edge N; pending[g] <= IDLE; present[g] <= on_off value.
REQ-019 Exactly one event per cycle maximum; outputs return to 0 at the next edge with no grant.
REQ-020 Latency: request sampled at edge N -> pending at N; earliest emission at edge N+1; worst case with all 4 pending: edge N+4.
REQ-021 Grant and new request for the same device at the same edge: grant uses the pre-edge pending state; the new request is evaluated against the pre-edge effective state and becomes the new pending state.
REQ-022 Sum of emitted (+1 join, -1 leave) always equals popcount(active_mask); the downstream counter never sees a duplicate.
REQ-023 No backpressure; the downstream stage accepts one change per cycle unconditionally.

Reset
REQ-024 While rst=1 (asynchronous): change=0, on_off=0, dev_id=0, active_mask=0, dup_err=0, all pending=IDLE, rr_ptr=0.
REQ-025 Requests sampled while rst=1 are discarded; pending events are lost when reset asserts mid-operation.
REQ-026 First sampling occurs on the first rising edge after rst deasserts.

Verification
REQ-027 Reset, then join=0001 for 1 cycle -> next edge change=1, on_off=1, dev_id=0; active_mask=0001; dup_err=0.
REQ-028 join=1111 in one cycle after reset -> four consecutive cycles change=1 with dev_id 0,1,2,3; active_mask=1111 afterwards.
REQ-029 Device 2 present; leave[2] at edge N, join[2] at edge N+1 before grant -> if rr grants 2 at N+1, emit leave then re-pend join (REQ-021); if pending was cancelled, no event, active_mask[2] stays 1.
REQ-030 join[1] held high 3 cycles from idle -> exactly one join event for device 1; dup_err=1.
REQ-031 join[3]=leave[3]=1 same cycle -> no event, active_mask unchanged, dup_err=1.
REQ-032 Devices 0 and 1 pending, rst pulsed asynchronously mid-cycle -> outputs 0 immediately; no events emitted after release.
